// File: rtl/return_address_stack.sv
// Purpose     : speculative return-address stack feeding JR/JALR target prediction to fetch.
// Latency     : an op presented in cycle N shows on predict_* / snap_* in cycle N+1.
// Backpressure: none; always accepts, fetch_valid qualifies every op, full pushes drop the oldest.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   fetch_valid         fetched instruction accepted this cycle
//   is_call/is_return   quick-decode flags of that instruction
//   call_pc             PC of the call; the pushed return address is call_pc + 8 (skips delay slot)
//   flush               backend redirect, wins over any same-cycle fetch op
//   flush_top/count     checkpoint to restore (ignored when RAS_COMMIT_STACK_EN is defined)
//   commit_*            retire-time ops for the architectural stack (RAS_COMMIT_STACK_EN only)
//   predict_valid       stack non-empty
//   predict_address     top entry, 0 when empty
//   snap_top/snap_count pointers fetch checkpoints alongside each branch
//
// Optional feature macro: RAS_COMMIT_STACK_EN (adds an architectural stack copied in on flush).

module return_address_stack #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_valid,
  input  logic          is_call,
  input  logic          is_return,
  input  logic [31:0]   call_pc,
  input  logic          flush,
  input  logic [AW-1:0] flush_top,
  input  logic [AW:0]   flush_count,
`ifdef RAS_COMMIT_STACK_EN
  input  logic          commit_valid,
  input  logic          commit_is_call,
  input  logic          commit_is_return,
  input  logic [31:0]   commit_call_pc,
`endif
  output logic          predict_valid,
  output logic [31:0]   predict_address,
  output logic [AW-1:0] snap_top,
  output logic [AW:0]   snap_count
);

  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  // Next-pointer result of one stack op; shared by the speculative and architectural stacks.
  typedef struct packed {
    logic [AW-1:0] top;
    logic [AW:0]   count;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
  } upd_t;

  function automatic upd_t f_upd(input logic          push,
                                 input logic          pop,
                                 input logic          repl,
                                 input logic [AW-1:0] top,
                                 input logic [AW:0]   count);
    upd_t u;
    u.top    = top;
    u.count  = count;
    u.wr_en  = 1'b0;
    u.wr_idx = top;
    if (push) begin
      // Pointer wraps naturally; when full the slot written is the oldest entry.
      u.top    = top + AW'(1);
      u.wr_en  = 1'b1;
      u.wr_idx = top + AW'(1);
      if (count != LP_FULL) u.count = count + (AW+1)'(1);
    end else if (pop) begin
      if (count != '0) begin
        u.top   = top - AW'(1);
        u.count = count - (AW+1)'(1);
      end
    end else if (repl) begin
      // Call+return in one instruction replaces the top in place.
      u.wr_en = 1'b1;
      if (count == '0) u.count = (AW+1)'(1);
    end
    return u;
  endfunction

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_top;
  logic [AW:0]   r_count;

  upd_t          w_upd;
  logic [31:0]   w_wr_dat;

  always_comb begin
    w_upd    = f_upd(fetch_valid & is_call & ~is_return,
                     fetch_valid & is_return & ~is_call,
                     fetch_valid & is_call & is_return,
                     r_top, r_count);
    w_wr_dat = call_pc + 32'd8;
  end

`ifdef RAS_COMMIT_STACK_EN
  // Architectural stack, updated at retire with the same rules.
  logic [31:0]   r_amem [DEPTH];
  logic [AW-1:0] r_atop;
  logic [AW:0]   r_acount;
  upd_t          w_aupd;
  logic [31:0]   w_amem_nxt [DEPTH];
  logic          w_unused_flush;

  // Post-commit view of the architectural stack, so a flush in the same
  // cycle as a commit copies the already-updated state.
  always_comb begin
    w_aupd = f_upd(commit_valid & commit_is_call & ~commit_is_return,
                   commit_valid & commit_is_return & ~commit_is_call,
                   commit_valid & commit_is_call & commit_is_return,
                   r_atop, r_acount);
    w_amem_nxt = r_amem;
    if (w_aupd.wr_en) w_amem_nxt[w_aupd.wr_idx] = commit_call_pc + 32'd8;
  end

  assign w_unused_flush = ^{flush_top, flush_count};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_atop   <= '0;
      r_acount <= '0;
      for (int i = 0; i < DEPTH; i++) r_amem[i] <= '0;
    end else begin
      r_atop   <= w_aupd.top;
      r_acount <= w_aupd.count;
      r_amem   <= w_amem_nxt;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_top   <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
`ifdef RAS_COMMIT_STACK_EN
      r_mem   <= w_amem_nxt;
      r_top   <= w_aupd.top;
      r_count <= w_aupd.count;
`else
      // Only pointers are restored; entries overwritten since the checkpoint stay stale.
      r_top   <= flush_top;
      r_count <= flush_count;
`endif
    end else begin
      r_top   <= w_upd.top;
      r_count <= w_upd.count;
      if (w_upd.wr_en) r_mem[w_upd.wr_idx] <= w_wr_dat;
    end
  end

  assign predict_valid   = (r_count != '0);
  assign predict_address = (r_count != '0) ? r_mem[r_top] : 32'd0;
  assign snap_top        = r_top;
  assign snap_count      = r_count;

`ifndef RAS_COMMIT_STACK_EN
  a_flush_count_legal: assert property (@(posedge clk) disable iff (rst)
    flush |-> (flush_count <= LP_FULL));
`endif

endmodule

// File: tb/tb_return_address_stack.sv
// Purpose     : randomized + directed check of return_address_stack against a behavioural model.
// Latency     : outputs compared 1 time unit after each rising edge that applied an op.
// Backpressure: n/a (DUT has no handshake).

module tb_return_address_stack;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_valid, is_call, is_return, flush;
  logic [31:0]   call_pc;
  logic [AW-1:0] flush_top;
  logic [AW:0]   flush_count;
  logic          predict_valid;
  logic [31:0]   predict_address;
  logic [AW-1:0] snap_top;
  logic [AW:0]   snap_count;
`ifdef RAS_COMMIT_STACK_EN
  logic          commit_valid, commit_is_call, commit_is_return;
  logic [31:0]   commit_call_pc;
`endif

  always #5 clk = ~clk;

  return_address_stack #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .is_call(is_call), .is_return(is_return), .call_pc(call_pc),
    .flush(flush), .flush_top(flush_top), .flush_count(flush_count),
`ifdef RAS_COMMIT_STACK_EN
    .commit_valid(commit_valid), .commit_is_call(commit_is_call),
    .commit_is_return(commit_is_return), .commit_call_pc(commit_call_pc),
`endif
    .predict_valid(predict_valid), .predict_address(predict_address),
    .snap_top(snap_top), .snap_count(snap_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: stack 0 is speculative, stack 1 architectural.
  logic [31:0] m_mem [2][DEPTH];
  int          m_top [2];
  int          m_cnt [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_top[s] = 0;
      m_cnt[s] = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[s][i] = 32'd0;
    end
  endtask

  task automatic model_op(input int s, input bit c, input bit r, input logic [31:0] pc);
    if (c && !r) begin
      m_top[s] = (m_top[s] + 1) % DEPTH;
      m_mem[s][m_top[s]] = pc + 32'd8;
      if (m_cnt[s] < DEPTH) m_cnt[s]++;
    end else if (r && !c) begin
      if (m_cnt[s] > 0) begin
        m_top[s] = (m_top[s] + DEPTH - 1) % DEPTH;
        m_cnt[s]--;
      end
    end else if (c && r) begin
      m_mem[s][m_top[s]] = pc + 32'd8;
      if (m_cnt[s] == 0) m_cnt[s] = 1;
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_valid"}, {31'd0, predict_valid}, {31'd0, m_cnt[0] != 0});
    chk({tag, "_addr"}, predict_address, (m_cnt[0] != 0) ? m_mem[0][m_top[0]] : 32'd0);
    chk({tag, "_top"}, {29'd0, snap_top}, m_top[0]);
    chk({tag, "_count"}, {28'd0, snap_count}, m_cnt[0]);
  endtask

  task automatic idle();
    fetch_valid = 0; is_call = 0; is_return = 0; call_pc = '0;
    flush = 0; flush_top = '0; flush_count = '0;
`ifdef RAS_COMMIT_STACK_EN
    commit_valid = 0; commit_is_call = 0; commit_is_return = 0; commit_call_pc = '0;
`endif
  endtask

  // One clock with the currently driven inputs; model advanced at the edge, outputs checked 1 later.
  task automatic step(input string tag);
    @(posedge clk);
`ifdef RAS_COMMIT_STACK_EN
    if (commit_valid) model_op(1, commit_is_call, commit_is_return, commit_call_pc);
`endif
    if (flush) begin
`ifdef RAS_COMMIT_STACK_EN
      m_mem[0] = m_mem[1];
      m_top[0] = m_top[1];
      m_cnt[0] = m_cnt[1];
`else
      m_top[0] = int'(flush_top);
      m_cnt[0] = int'(flush_count);
`endif
    end else if (fetch_valid) begin
      model_op(0, is_call, is_return, call_pc);
    end
    #1;
    check_outs(tag);
  endtask

  task automatic push(input logic [31:0] pc);
    idle(); fetch_valid = 1; is_call = 1; call_pc = pc;
    step("push");
  endtask

  task automatic pop();
    idle(); fetch_valid = 1; is_return = 1;
    step("pop");
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from the clock edge.
  task automatic do_reset();
    rst = 1;
    #2;
    model_reset();
    check_outs("rst");
    chk("rst_addr_zero", predict_address, 32'd0);
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle();
    model_reset();
    #12;
    // 1. reset state
    check_outs("t1");
    chk("t1_valid0", {31'd0, predict_valid}, 32'd0);
    chk("t1_count0", {28'd0, snap_count}, 32'd0);
    rst = 0;

    // 2. single push then pop
    push(32'h8000_0100);
    chk("t2_addr", predict_address, 32'h8000_0108);
    chk("t2_valid", {31'd0, predict_valid}, 32'd1);
    pop();
    chk("t2_empty", {31'd0, predict_valid}, 32'd0);

    // 3. overflow wraps over the oldest entry
    for (int i = 0; i <= 8; i++) push(32'h1000 + 32'(16 * i));
    chk("t3_count", {28'd0, snap_count}, 32'd8);
    chk("t3_top", predict_address, 32'h1088);
    for (int k = 0; k < 8; k++) begin
      chk("t3_popaddr", predict_address, 32'h1088 - 32'(16 * k));
      pop();
    end
    chk("t3_count_after8", {28'd0, snap_count}, 32'd0);
    pop();
    chk("t3_count_after9", {28'd0, snap_count}, 32'd0);

    // 4. empty pop and unqualified call leave pointers alone
    pop();
    chk("t4_top", {29'd0, snap_top}, 32'd1);
    idle(); is_call = 1; call_pc = 32'hdead_0000;
    step("t4_nofv");
    chk("t4_top2", {29'd0, snap_top}, 32'd1);
    chk("t4_count2", {28'd0, snap_count}, 32'd0);

`ifndef RAS_COMMIT_STACK_EN
    // 5. checkpoint restore; same-cycle push is dropped
    do_reset();
    push(32'h400);
    push(32'h500);
    chk("t5_snap_top", {29'd0, snap_top}, 32'd2);
    chk("t5_snap_cnt", {28'd0, snap_count}, 32'd2);
    push(32'h600);
    push(32'h700);
    idle(); flush = 1; flush_top = 3'd2; flush_count = 4'd2;
    fetch_valid = 1; is_call = 1; call_pc = 32'h900;
    step("t5_flush");
    chk("t5_addr", predict_address, 32'h508);
    chk("t5_count", {28'd0, snap_count}, 32'd2);
`else
    // 6. flush restores from the architectural stack
    do_reset();
    idle(); commit_valid = 1; commit_is_call = 1; commit_call_pc = 32'h2000;
    step("t6_commit");
    push(32'h3000);
    push(32'h3100);
    push(32'h3200);
    idle(); flush = 1;
    step("t6_flush");
    chk("t6_addr", predict_address, 32'h2008);
    chk("t6_count", {28'd0, snap_count}, 32'd1);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      idle();
      fetch_valid = ($urandom_range(0, 9) < 8);
      is_call     = $urandom_range(0, 1) == 1;
      is_return   = $urandom_range(0, 1) == 1;
      call_pc     = $urandom;
      flush       = ($urandom_range(0, 15) == 0);
      flush_top   = AW'($urandom_range(0, DEPTH - 1));
      flush_count = (AW+1)'($urandom_range(0, DEPTH));
`ifdef RAS_COMMIT_STACK_EN
      commit_valid     = $urandom_range(0, 2) == 0;
      commit_is_call   = $urandom_range(0, 1) == 1;
      commit_is_return = $urandom_range(0, 1) == 1;
      commit_call_pc   = $urandom;
`endif
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
